demux_1in_3out_hs: RTL and testbench
====================================

Name: demux_1in_3out_hs

Overview:
- Registered 1-to-3 distributor; the write-side counterpart of the 3-to-1 selection mux used in the datapath.
- Accepts one data word plus a 2-bit destination select over a valid/ready handshake.
- Buffers the word in a single-entry holding register and presents it to the selected destination port (A, B or C), each with its own valid/ready handshake.
- Used wherever one producer (e.g. writeback/forward result) must feed one of three consumers that may stall independently.

Parameters:
- DB, 32, data width in bits of input and all three outputs.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  synchronous active-low reset
- DatoIn  input  DB  data word to route
- Sel  input  2  destination: 0=A, 1=B, 2=C, 3=C (same encoding as the 3-to-1 mux)
- InValid  input  1  DatoIn/Sel valid this cycle
- InReady  output  1  block can accept a word this cycle
- DatoA / DatoB / DatoC  output  DB  registered data to destinations A/B/C
- ValidA / ValidB / ValidC  output  1  word pending for destination A/B/C
- ReadyA / ReadyB / ReadyC  input  1  destination accepts this cycle

Behaviour:
- Reset (rst_n=0 at clk edge): holding register empty; done mask cleared.
  - Reset values: DatoA/B/C=0, ValidA/B/C=0, InReady=0 during reset cycle, InReady=1 from first cycle after release.
- State: buf_valid, buf_data[DB-1:0], buf_sel[1:0], done_mask[2:0]. Two states: EMPTY (buf_valid=0), FULL (buf_valid=1).
- Target mask from buf_sel: 0→001(A), 1→010(B), 2→100(C), 3→100(C).
- ValidX = buf_valid & target[X] & ~done_mask[X]. DatoX = buf_data for all three, held stable while FULL.
- Transfer on output X when ValidX & ReadyX.
- complete = buf_valid & every target bit is either in done_mask or transferring this cycle.
- InReady = ~buf_valid | complete (combinational; allows back-to-back words at full throughput).
- Input accept when InValid & InReady: buf_data←DatoIn, buf_sel←Sel, buf_valid←1, done_mask←0.
- Latency: word accepted at edge N appears with ValidX=1 in the cycle after edge N (1 cycle).
- complete without new input: buf_valid←0, done_mask←0.
- Partial progress (broadcast only): done_mask |= transfers this cycle.
- Stall: while ReadyX=0, ValidX stays 1 and DatoX stays unchanged; no word is dropped or duplicated.
- Simultaneous complete and input accept in the same cycle: new word loads, no bubble.
- Sel and DatoIn are ignored when InValid=0 or InReady=0.
- ReadyX with ValidX=0 has no effect.
- Reset mid-operation: the pending word is discarded and all ValidX drop in the same edge.

Optional Feature:
- Macro: DEMUX_BROADCAST_EN.
- Defined: Sel=3 target mask = 111. The word is broadcast to A, B and C, each handshaking independently. done_mask records completed ports. InReady rises only when the last outstanding port transfers.
- Undefined: Sel=3 routes to C only (mask 100), done_mask is constant 0, and its logic may be optimised away.

Decomposition:
- Shared include/package: DEMUX_SEL_A=2'd0, DEMUX_SEL_B=2'd1, DEMUX_SEL_C=2'd2, DEMUX_SEL_ALL=2'd3, plus the sel→target-mask function. The 3-to-1 mux uses the same encodings.
- No sub-module required. Optionally split a one-entry handshake buffer "hs_hold_reg" (data+valid, load/clear). Routing logic stays in the top module.

Test Plan:
- Reset: hold rst_n=0 two cycles with InValid=1 → all ValidX=0, DatoX=0, and InReady=1 on first cycle after release.
- Single route: DatoIn=32'hDEADBEEF, Sel=1, InValid=1, ReadyB=1 → next cycle ValidB=1, DatoB=32'hDEADBEEF, ValidA=ValidC=0. Transfer completes in that cycle.
- Stall: Sel=0, DatoIn=32'h1, ReadyA=0 for 5 cycles → ValidA=1 and DatoA=1 stable, InReady=0. ReadyA=1 → transfer, InReady=1 the same cycle.
- Back-to-back: words 0x10 (Sel=0), 0x20 (Sel=2), 0x30 (Sel=3) on consecutive cycles, all Ready=1 → one word per cycle on A, C, C respectively, with no bubbles.
- Broadcast (DEMUX_BROADCAST_EN): Sel=3, DatoIn=0xABCD, ReadyA=1, ReadyB=0, ReadyC=0 → A transfers and ValidA drops. B then C released on later cycles → InReady=1 only in C's transfer cycle. Without the macro, same stimulus → only ValidC=1.
- Mid-operation reset: word pending on B with ReadyB=0, rst_n=0 for one cycle → ValidB=0 next cycle. No later transfer of the discarded word.

Source files
------------

// File: rtl/demux_1in_3out_hs_pkg.sv
// -----------------------------------------------------------------------------
// demux_1in_3out_hs_pkg
//   Shared definitions for the 1-to-3 handshake distributor. The 3-to-1
//   selection mux in the datapath uses the same select encodings.
//
//   Contents:
//     DEMUX_SEL_*      destination select encodings
//     buf_state_e      holding-register state (EMPTY / FULL)
//     dest_mask_t      one-hot/broadcast destination mask {C, B, A}
//     sel_to_mask()    select -> destination mask
//
//   Configuration macro: DEMUX_BROADCAST_EN
//     defined   : select 3 targets A, B and C (mask 111)
//     undefined : select 3 targets C only (mask 100)
// -----------------------------------------------------------------------------
package demux_1in_3out_hs_pkg;

  localparam logic [1:0] DEMUX_SEL_A   = 2'd0;
  localparam logic [1:0] DEMUX_SEL_B   = 2'd1;
  localparam logic [1:0] DEMUX_SEL_C   = 2'd2;
  localparam logic [1:0] DEMUX_SEL_ALL = 2'd3;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } buf_state_e;

  // Bit 0 = A, bit 1 = B, bit 2 = C.
  typedef logic [2:0] dest_mask_t;

  function automatic dest_mask_t sel_to_mask(input logic [1:0] sel);
    dest_mask_t mask;
    case (sel)
      DEMUX_SEL_A: mask = 3'b001;
      DEMUX_SEL_B: mask = 3'b010;
      DEMUX_SEL_C: mask = 3'b100;
`ifdef DEMUX_BROADCAST_EN
      default:     mask = 3'b111;
`else
      default:     mask = 3'b100;
`endif
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/demux_1in_3out_hs.sv
// -----------------------------------------------------------------------------
// demux_1in_3out_hs
//   Registered 1-to-3 distributor. One producer hands over a word plus a
//   destination select on a valid/ready handshake. The word is held in a
//   single-entry buffer and offered to destination A, B or C, each with its
//   own valid/ready handshake, so the consumers can stall independently.
//
//   Ports:
//     clk                    system clock, all state on rising edge
//     rst_n                  synchronous active-low reset
//     DatoIn[DB-1:0]         data word to route
//     Sel[1:0]               destination: 0=A, 1=B, 2=C, 3=C (or all, see below)
//     InValid / InReady      input handshake
//     DatoA/B/C[DB-1:0]      registered data to each destination
//     ValidA/B/C             word pending for that destination
//     ReadyA/B/C             destination accepts this cycle
//
//   Configuration macro: DEMUX_BROADCAST_EN
//     defined   : Sel=3 broadcasts to A, B and C; a done mask tracks which
//                 ports have already taken the word.
//     undefined : Sel=3 goes to C only and the done mask is constant zero.
// -----------------------------------------------------------------------------
module demux_1in_3out_hs
  import demux_1in_3out_hs_pkg::*;
#(
  parameter int DB = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DB-1:0] DatoIn,
  input  logic [1:0]    Sel,
  input  logic          InValid,
  output logic          InReady,
  output logic [DB-1:0] DatoA,
  output logic [DB-1:0] DatoB,
  output logic [DB-1:0] DatoC,
  output logic          ValidA,
  output logic          ValidB,
  output logic          ValidC,
  input  logic          ReadyA,
  input  logic          ReadyB,
  input  logic          ReadyC
);

  buf_state_e    state_q, state_d;
  logic [DB-1:0] buf_data_q, buf_data_d;
  logic [1:0]    buf_sel_q, buf_sel_d;

  logic          buf_valid;
  dest_mask_t    target;
  dest_mask_t    done_mask;
  dest_mask_t    ready_vec;
  dest_mask_t    valid_vec;
  dest_mask_t    xfer;
  logic          complete;
  logic          accept;

  assign buf_valid = (state_q == ST_FULL);
  assign target    = sel_to_mask(buf_sel_q);
  assign ready_vec = {ReadyC, ReadyB, ReadyA};
  assign valid_vec = {3{buf_valid}} & target & ~done_mask;
  assign xfer      = valid_vec & ready_vec;

  // The word is finished once every targeted port has either taken it
  // earlier or is taking it now.
  assign complete  = buf_valid & ~|(target & ~(done_mask | xfer));

  // Gating with rst_n keeps InReady low while reset is asserted; after
  // release the buffer is empty, so InReady rises immediately.
  assign InReady   = rst_n & (~buf_valid | complete);
  assign accept    = InValid & InReady;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    buf_data_d = buf_data_q;
    buf_sel_d  = buf_sel_q;
    if (accept) begin
      // Covers both the empty case and complete-plus-refill in one cycle.
      state_d    = ST_FULL;
      buf_data_d = DatoIn;
      buf_sel_d  = Sel;
    end else if (complete) begin
      state_d    = ST_EMPTY;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      // NOTE: the data register is reset because the outputs it drives
      // must read zero out of reset, not merely be qualified by Valid.
      buf_data_q <= '0;
      buf_sel_q  <= DEMUX_SEL_A;
    end else begin
      state_q    <= state_d;
      buf_data_q <= buf_data_d;
      buf_sel_q  <= buf_sel_d;
    end
  end

`ifdef DEMUX_BROADCAST_EN
  dest_mask_t done_mask_q, done_mask_d;

  // Ports that already took a broadcast word are masked off until the last
  // outstanding port transfers; a new word always starts with a clear mask.
  always_comb begin
    done_mask_d = done_mask_q;
    if (accept || complete) begin
      done_mask_d = '0;
    end else if (buf_valid) begin
      done_mask_d = done_mask_q | xfer;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done_mask_q <= '0;
    end else begin
      done_mask_q <= done_mask_d;
    end
  end

  assign done_mask = done_mask_q;
`else
  // Single-destination routing completes in one transfer, nothing to track.
  assign done_mask = '0;
`endif

  assign DatoA  = buf_data_q;
  assign DatoB  = buf_data_q;
  assign DatoC  = buf_data_q;
  assign ValidA = valid_vec[0];
  assign ValidB = valid_vec[1];
  assign ValidC = valid_vec[2];

endmodule

// File: tb/tb_demux_1in_3out_hs.sv
// -----------------------------------------------------------------------------
// tb_demux_1in_3out_hs
//   Directed testbench for demux_1in_3out_hs. Inputs change 1 time unit after
//   the rising edge; outputs are compared 1 time unit after that.
//   Honours DEMUX_BROADCAST_EN for the Sel=3 expectations.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_demux_1in_3out_hs;

  localparam int DB = 32;

  logic          clk;
  logic          rst_n;
  logic [DB-1:0] DatoIn;
  logic [1:0]    Sel;
  logic          InValid;
  logic          InReady;
  logic [DB-1:0] DatoA, DatoB, DatoC;
  logic          ValidA, ValidB, ValidC;
  logic          ReadyA, ReadyB, ReadyC;

  int n_total = 0;
  int n_pass  = 0;
  int cnt_a   = 0;
  int cnt_b   = 0;
  int cnt_c   = 0;

  demux_1in_3out_hs #(.DB(DB)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .DatoIn  (DatoIn),
    .Sel     (Sel),
    .InValid (InValid),
    .InReady (InReady),
    .DatoA   (DatoA),
    .DatoB   (DatoB),
    .DatoC   (DatoC),
    .ValidA  (ValidA),
    .ValidB  (ValidB),
    .ValidC  (ValidC),
    .ReadyA  (ReadyA),
    .ReadyB  (ReadyB),
    .ReadyC  (ReadyC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transfer counters: detect dropped or duplicated words per port.
  always @(posedge clk) begin
    if (ValidA && ReadyA) cnt_a <= cnt_a + 1;
    if (ValidB && ReadyB) cnt_b <= cnt_b + 1;
    if (ValidC && ReadyC) cnt_c <= cnt_c + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; InValid = 1'b1; DatoIn = 32'hFFFF_FFFF; Sel = 2'd1;
    ReadyA = 1'b0; ReadyB = 1'b0; ReadyC = 1'b0;
    tick(); tick();
    #1;
    n_total++; if ({ValidA, ValidB, ValidC} !== 3'b000) $display("FAIL reset_valid: got %b expected 000", {ValidA, ValidB, ValidC}); else n_pass++;
    n_total++; if ({DatoA, DatoB, DatoC} !== 96'h0) $display("FAIL reset_data: got %h expected 0", {DatoA, DatoB, DatoC}); else n_pass++;
    n_total++; if (InReady !== 1'b0) $display("FAIL reset_inready_low: got %b expected 0", InReady); else n_pass++;
    rst_n = 1'b1; InValid = 1'b0;
    #1;
    n_total++; if (InReady !== 1'b1) $display("FAIL reset_inready_release: got %b expected 1", InReady); else n_pass++;
    tick();
  endtask

  task automatic test_single_route();
    int b0;
    b0 = cnt_b;
    DatoIn = 32'hDEAD_BEEF; Sel = 2'd1; InValid = 1'b1; ReadyB = 1'b1;
    tick();
    InValid = 1'b0;
    #1;
    n_total++; if (ValidB !== 1'b1) $display("FAIL single_validb: got %b expected 1", ValidB); else n_pass++;
    n_total++; if (DatoB !== 32'hDEAD_BEEF) $display("FAIL single_datob: got %h expected deadbeef", DatoB); else n_pass++;
    n_total++; if ({ValidA, ValidC} !== 2'b00) $display("FAIL single_others: got %b expected 00", {ValidA, ValidC}); else n_pass++;
    n_total++; if (InReady !== 1'b1) $display("FAIL single_inready: got %b expected 1", InReady); else n_pass++;
    tick();
    ReadyB = 1'b0;
    #1;
    n_total++; if (ValidB !== 1'b0) $display("FAIL single_drained: got %b expected 0", ValidB); else n_pass++;
    n_total++; if (cnt_b - b0 !== 1) $display("FAIL single_count: got %0d expected 1", cnt_b - b0); else n_pass++;
  endtask

  task automatic test_stall();
    int a0, b0;
    a0 = cnt_a; b0 = cnt_b;
    DatoIn = 32'h1; Sel = 2'd0; InValid = 1'b1;
    ReadyA = 1'b0; ReadyB = 1'b0; ReadyC = 1'b0;
    tick();
    // A competing word is offered throughout the stall and must be ignored.
    DatoIn = 32'hBAD; Sel = 2'd1; InValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_total++; if (ValidA !== 1'b1 || DatoA !== 32'h1) $display("FAIL stall_hold[%0d]: got valid=%b data=%h expected valid=1 data=1", i, ValidA, DatoA); else n_pass++;
      n_total++; if (InReady !== 1'b0 || ValidB !== 1'b0) $display("FAIL stall_block[%0d]: got inready=%b validb=%b expected 0 0", i, InReady, ValidB); else n_pass++;
      tick();
    end
    ReadyA = 1'b1;
    #1;
    n_total++; if (InReady !== 1'b1) $display("FAIL stall_release_inready: got %b expected 1", InReady); else n_pass++;
    tick();
    // Completion and refill happened on the same edge: 0xBAD now waits on B.
    InValid = 1'b0; ReadyA = 1'b0; ReadyB = 1'b1;
    #1;
    n_total++; if (ValidA !== 1'b0 || ValidB !== 1'b1 || DatoB !== 32'hBAD) $display("FAIL stall_refill: got va=%b vb=%b db=%h expected 0 1 bad", ValidA, ValidB, DatoB); else n_pass++;
    tick();
    ReadyB = 1'b0;
    #1;
    n_total++; if (ValidB !== 1'b0 || InReady !== 1'b1) $display("FAIL stall_drained: got vb=%b inready=%b expected 0 1", ValidB, InReady); else n_pass++;
    n_total++; if (cnt_a - a0 !== 1 || cnt_b - b0 !== 1) $display("FAIL stall_count: got a=%0d b=%0d expected 1 1", cnt_a - a0, cnt_b - b0); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_v;
`ifdef DEMUX_BROADCAST_EN
    exp_v = 3'b111;
`else
    exp_v = 3'b100;
`endif
    ReadyA = 1'b1; ReadyB = 1'b1; ReadyC = 1'b1;
    DatoIn = 32'h10; Sel = 2'd0; InValid = 1'b1;
    #1;
    n_total++; if (InReady !== 1'b1) $display("FAIL b2b_inready0: got %b expected 1", InReady); else n_pass++;
    tick();
    DatoIn = 32'h20; Sel = 2'd2;
    #1;
    n_total++; if (ValidA !== 1'b1 || DatoA !== 32'h10 || InReady !== 1'b1) $display("FAIL b2b_word1: got va=%b da=%h inready=%b expected 1 10 1", ValidA, DatoA, InReady); else n_pass++;
    tick();
    DatoIn = 32'h30; Sel = 2'd3;
    #1;
    n_total++; if ({ValidC, ValidB, ValidA} !== 3'b100 || DatoC !== 32'h20 || InReady !== 1'b1) $display("FAIL b2b_word2: got v=%b dc=%h inready=%b expected 100 20 1", {ValidC, ValidB, ValidA}, DatoC, InReady); else n_pass++;
    tick();
    InValid = 1'b0;
    #1;
    n_total++; if ({ValidC, ValidB, ValidA} !== exp_v || DatoC !== 32'h30) $display("FAIL b2b_word3: got v=%b dc=%h expected %b 30", {ValidC, ValidB, ValidA}, DatoC, exp_v); else n_pass++;
    tick();
    ReadyA = 1'b0; ReadyB = 1'b0; ReadyC = 1'b0;
    #1;
    n_total++; if ({ValidC, ValidB, ValidA} !== 3'b000 || InReady !== 1'b1) $display("FAIL b2b_drained: got v=%b inready=%b expected 000 1", {ValidC, ValidB, ValidA}, InReady); else n_pass++;
  endtask

  task automatic test_broadcast();
    int a0, b0, c0;
    a0 = cnt_a; b0 = cnt_b; c0 = cnt_c;
    DatoIn = 32'hABCD; Sel = 2'd3; InValid = 1'b1;
    ReadyA = 1'b1; ReadyB = 1'b0; ReadyC = 1'b0;
    tick();
    InValid = 1'b0;
    #1;
`ifdef DEMUX_BROADCAST_EN
    n_total++; if ({ValidC, ValidB, ValidA} !== 3'b111 || InReady !== 1'b0) $display("FAIL bc_start: got v=%b inready=%b expected 111 0", {ValidC, ValidB, ValidA}, InReady); else n_pass++;
    tick();
    #1;
    n_total++; if ({ValidC, ValidB, ValidA} !== 3'b110 || InReady !== 1'b0) $display("FAIL bc_after_a: got v=%b inready=%b expected 110 0", {ValidC, ValidB, ValidA}, InReady); else n_pass++;
    ReadyB = 1'b1;
    #1;
    n_total++; if (InReady !== 1'b0) $display("FAIL bc_b_xfer_inready: got %b expected 0", InReady); else n_pass++;
    tick();
    #1;
    n_total++; if ({ValidC, ValidB, ValidA} !== 3'b100 || InReady !== 1'b0 || DatoC !== 32'hABCD) $display("FAIL bc_after_b: got v=%b inready=%b dc=%h expected 100 0 abcd", {ValidC, ValidB, ValidA}, InReady, DatoC); else n_pass++;
    ReadyC = 1'b1;
    #1;
    n_total++; if (InReady !== 1'b1) $display("FAIL bc_c_xfer_inready: got %b expected 1", InReady); else n_pass++;
    tick();
    ReadyA = 1'b0; ReadyB = 1'b0; ReadyC = 1'b0;
    #1;
    n_total++; if ({ValidC, ValidB, ValidA} !== 3'b000 || InReady !== 1'b1) $display("FAIL bc_done: got v=%b inready=%b expected 000 1", {ValidC, ValidB, ValidA}, InReady); else n_pass++;
    n_total++; if (cnt_a - a0 !== 1 || cnt_b - b0 !== 1 || cnt_c - c0 !== 1) $display("FAIL bc_count: got a=%0d b=%0d c=%0d expected 1 1 1", cnt_a - a0, cnt_b - b0, cnt_c - c0); else n_pass++;
`else
    n_total++; if ({ValidC, ValidB, ValidA} !== 3'b100 || InReady !== 1'b0 || DatoC !== 32'hABCD) $display("FAIL sel3_start: got v=%b inready=%b dc=%h expected 100 0 abcd", {ValidC, ValidB, ValidA}, InReady, DatoC); else n_pass++;
    tick();
    ReadyB = 1'b1;
    #1;
    n_total++; if ({ValidC, ValidB, ValidA} !== 3'b100 || InReady !== 1'b0) $display("FAIL sel3_stalled: got v=%b inready=%b expected 100 0", {ValidC, ValidB, ValidA}, InReady); else n_pass++;
    tick();
    ReadyC = 1'b1;
    #1;
    n_total++; if (InReady !== 1'b1) $display("FAIL sel3_c_xfer_inready: got %b expected 1", InReady); else n_pass++;
    tick();
    ReadyA = 1'b0; ReadyB = 1'b0; ReadyC = 1'b0;
    #1;
    n_total++; if ({ValidC, ValidB, ValidA} !== 3'b000 || InReady !== 1'b1) $display("FAIL sel3_done: got v=%b inready=%b expected 000 1", {ValidC, ValidB, ValidA}, InReady); else n_pass++;
    n_total++; if (cnt_a - a0 !== 0 || cnt_b - b0 !== 0 || cnt_c - c0 !== 1) $display("FAIL sel3_count: got a=%0d b=%0d c=%0d expected 0 0 1", cnt_a - a0, cnt_b - b0, cnt_c - c0); else n_pass++;
`endif
  endtask

  task automatic test_mid_reset();
    int b0;
    b0 = cnt_b;
    DatoIn = 32'h55; Sel = 2'd1; InValid = 1'b1;
    ReadyA = 1'b0; ReadyB = 1'b0; ReadyC = 1'b0;
    tick();
    InValid = 1'b0;
    #1;
    n_total++; if (ValidB !== 1'b1 || DatoB !== 32'h55) $display("FAIL midrst_pending: got vb=%b db=%h expected 1 55", ValidB, DatoB); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++; if (InReady !== 1'b0) $display("FAIL midrst_inready: got %b expected 0", InReady); else n_pass++;
    tick();
    rst_n = 1'b1;
    #1;
    n_total++; if (ValidB !== 1'b0 || DatoB !== 32'h0 || InReady !== 1'b1) $display("FAIL midrst_cleared: got vb=%b db=%h inready=%b expected 0 0 1", ValidB, DatoB, InReady); else n_pass++;
    ReadyB = 1'b1;
    tick(); tick(); tick();
    ReadyB = 1'b0;
    #1;
    n_total++; if (cnt_b - b0 !== 0 || ValidB !== 1'b0) $display("FAIL midrst_no_xfer: got count=%0d vb=%b expected 0 0", cnt_b - b0, ValidB); else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0; InValid = 1'b0; DatoIn = '0; Sel = 2'd0;
    ReadyA = 1'b0; ReadyB = 1'b0; ReadyC = 1'b0;
    test_reset();
    test_single_route();
    test_stall();
    test_back_to_back();
    test_broadcast();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
